// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the exclusive-access monitor: transfer-type
// encodings and the reservation tag width helper.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE = 2'b00,
        HTRANS_BUSY = 2'b01,
        HTRANS_NSEQ = 2'b10,
        HTRANS_SEQ  = 2'b11
    } htrans_e;

    function automatic int rsv_tag_w(input int w_addr, input int granule_log2);
        return w_addr - granule_log2;
    endfunction

endpackage

// File: rtl/ahbl_excl_rsv_slot.sv
// One exclusive reservation: valid bit plus granule tag, with an optional
// lifetime counter when AHBL_EXCL_MONITOR_TIMEOUT_EN is defined.
module ahbl_excl_rsv_slot #(
    parameter int W_TAG = 30
`ifdef AHBL_EXCL_MONITOR_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [W_TAG-1:0] tag_i,
    output logic             match_o
);

    logic             valid_q, valid_d;
    logic [W_TAG-1:0] tag_q, tag_d;

    assign match_o = valid_q & (tag_q == tag_i);

`ifdef AHBL_EXCL_MONITOR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear is applied last so it beats both a same-cycle set and expiry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (valid_q) begin
            if (cnt_q == '0) valid_d = 1'b0;
            else             cnt_d   = cnt_q - CNT_W'(1);
        end
        if (set_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
            cnt_d   = CNT_W'(TIMEOUT_CYCLES);
        end
        if (clr_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (set_i) begin
            valid_d = 1'b1;
            tag_d   = tag_i;
        end
        if (clr_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end
`endif

endmodule

// File: rtl/ahbl_excl_monitor.sv
// Inline AHB-Lite global exclusive monitor: one reservation per master, failed
// exclusive writes are turned into IDLE. Optional reservation timeout: AHBL_EXCL_MONITOR_TIMEOUT_EN.
module ahbl_excl_monitor
    import ahbl_pkg::*;
#(
    parameter int W_ADDR         = 32,
    parameter int W_DATA         = 32,
    parameter int N_MASTERS      = 2,
    parameter int GRANULE_LOG2   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_hready,
    output logic              src_hready_resp,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic              src_hexcl,
    input  logic [7:0]        src_hmaster,
    output logic              src_hexokay,
    output logic              dst_hready,
    input  logic              dst_hready_resp,
    input  logic              dst_hresp,
    input  logic [W_DATA-1:0] dst_hrdata,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [2:0]        dst_hburst,
    output logic [3:0]        dst_hprot,
    output logic              dst_hmastlock,
    output logic [W_DATA-1:0] dst_hwdata
);

    localparam int W_TAG = rsv_tag_w(W_ADDR, GRANULE_LOG2);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic                 accept, in_range, own_match, suppress, okay;
    logic [W_TAG-1:0]     tag;
    logic [N_MASTERS-1:0] slot_set, slot_clr, slot_match;
    logic                 dph_excl_q, dph_excl_d;
    logic                 dph_okay_q, dph_okay_d;
    logic                 dph_suppress_q, dph_suppress_d;

    assign tag = src_haddr[W_ADDR-1:GRANULE_LOG2];

    // A failed exclusive write only drops the writer's own reservation; any
    // forwarded write drops every reservation on the same granule.
    always_comb begin
        accept    = src_hready & src_htrans[1];
        in_range  = 1'b0;
        own_match = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (src_hmaster == 8'(i)) begin
                in_range  = 1'b1;
                own_match = slot_match[i];
            end
        end
        suppress = accept & src_hexcl & src_hwrite & ~own_match;
        okay     = src_hwrite ? own_match : in_range;
        for (int i = 0; i < N_MASTERS; i++) begin
            slot_set[i] = accept & src_hexcl & ~src_hwrite & (src_hmaster == 8'(i));
            slot_clr[i] = accept & src_hwrite &
                          ((slot_match[i] & ~suppress) | (src_hexcl & (src_hmaster == 8'(i))));
        end
    end

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_slot
        ahbl_excl_rsv_slot #(
            .W_TAG(W_TAG)
`ifdef AHBL_EXCL_MONITOR_TIMEOUT_EN
            ,
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .set_i  (slot_set[g]),
            .clr_i  (slot_clr[g]),
            .tag_i  (tag),
            .match_o(slot_match[g])
        );
    end

    always_comb begin
        dph_excl_d     = dph_excl_q;
        dph_okay_d     = dph_okay_q;
        dph_suppress_d = dph_suppress_q;
        if (src_hready) begin
            dph_excl_d     = accept & src_hexcl;
            dph_okay_d     = okay;
            dph_suppress_d = suppress;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_excl_q     <= 1'b0;
            dph_okay_q     <= 1'b0;
            dph_suppress_q <= 1'b0;
        end else begin
            dph_excl_q     <= dph_excl_d;
            dph_okay_q     <= dph_okay_d;
            dph_suppress_q <= dph_suppress_d;
        end
    end

    assign src_hexokay     = dph_excl_q & dph_okay_q;
    assign src_hready_resp = dph_suppress_q | dst_hready_resp;
    assign src_hresp       = ~dph_suppress_q & dst_hresp;
    assign src_hrdata      = dst_hrdata;

    assign dst_hready    = src_hready;
    assign dst_haddr     = src_haddr;
    assign dst_hwrite    = src_hwrite;
    assign dst_htrans    = suppress ? HTRANS_IDLE : src_htrans;
    assign dst_hsize     = src_hsize;
    assign dst_hburst    = src_hburst;
    assign dst_hprot     = src_hprot;
    assign dst_hmastlock = src_hmastlock;
    assign dst_hwdata    = src_hwdata;

endmodule

// File: tb/tb_ahbl_excl_monitor.sv
// Bench for ahbl_excl_monitor: single-slave AHB-Lite loop with a wait-state
// memory model and a data-phase response scoreboard.
module tb_ahbl_excl_monitor;
    import ahbl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src_hready, src_hready_resp, src_hresp;
    logic [31:0] src_haddr, src_hwdata, src_hrdata;
    logic        src_hwrite, src_hmastlock, src_hexcl, src_hexokay;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize, src_hburst;
    logic [3:0]  src_hprot;
    logic [7:0]  src_hmaster;
    logic        dst_hready, dst_hready_resp, dst_hresp, dst_hwrite, dst_hmastlock;
    logic [31:0] dst_hrdata, dst_haddr, dst_hwdata;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;

`ifdef AHBL_EXCL_MONITOR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Single-master bus: the upstream ready is the data-phase ready.
    assign src_hready = src_hready_resp;

    ahbl_excl_monitor #(
        .W_ADDR(32), .W_DATA(32), .N_MASTERS(2), .GRANULE_LOG2(3), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_hready(src_hready), .src_hready_resp(src_hready_resp), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .src_hexcl(src_hexcl), .src_hmaster(src_hmaster), .src_hexokay(src_hexokay),
        .dst_hready(dst_hready), .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp),
        .dst_hrdata(dst_hrdata), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
        .dst_htrans(dst_htrans), .dst_hsize(dst_hsize), .dst_hburst(dst_hburst),
        .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata)
    );

    // Slave memory with configurable wait states.
    logic [31:0] mem [0:1023];
    logic        s_pend, s_wr;
    logic [9:0]  s_idx;
    int          s_ws_cnt;
    int          ws_cfg = 0;

    assign dst_hready_resp = !s_pend || (s_ws_cnt == 0);
    assign dst_hrdata      = (s_pend && !s_wr) ? mem[s_idx] : 32'h0;
    assign dst_hresp       = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pend   <= 1'b0;
            s_wr     <= 1'b0;
            s_idx    <= '0;
            s_ws_cnt <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
        end else if (s_pend && s_ws_cnt != 0) begin
            s_ws_cnt <= s_ws_cnt - 1;
        end else begin
            if (s_pend && s_wr) mem[s_idx] <= dst_hwdata;
            if (dst_hready) begin
                s_pend   <= dst_htrans[1];
                s_wr     <= dst_hwrite;
                s_idx    <= dst_haddr[11:2];
                s_ws_cnt <= ws_cfg;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected data-phase responses.
    typedef struct {
        logic        okay;
        logic        resp;
        logic        chk_rd;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_act;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mon_act <= 1'b0;
        else if (src_hready) mon_act <= src_htrans[1];
    end

    always @(negedge clk) begin
        if (rst_n && mon_act && src_hready_resp) begin
            if (sb.size() == 0) begin
                chk("unexpected_dphase", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, " hexokay"}, 32'(src_hexokay), 32'(mon_e.okay));
                chk({mon_e.name, " hresp"}, 32'(src_hresp), 32'(mon_e.resp));
                if (mon_e.chk_rd) chk({mon_e.name, " hrdata"}, src_hrdata, mon_e.rdata);
            end
        end
    end

    task automatic idle_bus();
        src_htrans = HTRANS_IDLE;
        src_hexcl  = 1'b0;
        src_hwrite = 1'b0;
    endtask

    // Non-pipelined transfer; called #1 after a rising edge.
    task automatic xfer(input string name, input logic [31:0] addr, input logic wr,
                        input logic ex, input logic [7:0] m, input logic [31:0] wdata,
                        input logic exp_okay, input logic exp_sup,
                        input logic chk_rd, input logic [31:0] rdata, output int stalls);
        int n;
        src_haddr   = addr;
        src_hwrite  = wr;
        src_hexcl   = ex;
        src_hmaster = m;
        src_htrans  = HTRANS_NSEQ;
        stalls      = 0;
        n = 0;
        @(negedge clk);
        while (!src_hready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk({name, " accept_timeout"}, 32'd1, 32'd0);
            idle_bus();
            return;
        end
        chk({name, " dst_htrans"}, 32'(dst_htrans), exp_sup ? 32'd0 : 32'd2);
        sb.push_back('{exp_okay, 1'b0, chk_rd, rdata, name});
        @(posedge clk);
        #1;
        idle_bus();
        src_hwdata = wdata;
        @(negedge clk);
        if (exp_sup) chk({name, " sup_first_ready"}, 32'(src_hready_resp), 32'd1);
        n = 0;
        while (!src_hready_resp && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({name, " dphase_timeout"}, 32'd1, 32'd0);
        stalls = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st;
        rst_n         = 1'b0;
        src_haddr     = '0;
        src_hwdata    = '0;
        src_hsize     = 3'b010;
        src_hburst    = 3'b000;
        src_hprot     = 4'b0011;
        src_hmastlock = 1'b0;
        src_hmaster   = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst hexokay", 32'(src_hexokay), 32'd0);
        chk("rst hresp", 32'(src_hresp), 32'd0);
        chk("rst hready_resp", 32'(src_hready_resp), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exclusive pair succeeds, the reservation is consumed.
        xfer("t1_exr", 32'h100, 0, 1, 8'd0, 0, 1, 0, 1, 32'hA500_0040, st);
        xfer("t1_exw", 32'h100, 1, 1, 8'd0, 32'h1111, 1, 0, 0, 0, st);
        xfer("t1_exw_again", 32'h100, 1, 1, 8'd0, 32'h2222, 0, 1, 0, 0, st);
        xfer("t1_rd", 32'h100, 0, 0, 8'd0, 0, 0, 0, 1, 32'h1111, st);

        // Plain write to the same 8-byte granule breaks M0's reservation.
        xfer("t2_exr", 32'h100, 0, 1, 8'd0, 0, 1, 0, 1, 32'h1111, st);
        xfer("t2_wr_m1", 32'h104, 1, 0, 8'd1, 32'h3333, 0, 0, 0, 0, st);
        ws_cfg = 3;
        xfer("t2_exw", 32'h100, 1, 1, 8'd0, 32'h4444, 0, 1, 0, 0, st);
        ws_cfg = 0;
        xfer("t2_rd100", 32'h100, 0, 0, 8'd0, 0, 0, 0, 1, 32'h1111, st);
        xfer("t2_rd104", 32'h104, 0, 0, 8'd0, 0, 0, 0, 1, 32'h3333, st);

        // Competing reservations: first writer wins.
        xfer("t3_exr_m0", 32'h200, 0, 1, 8'd0, 0, 1, 0, 1, 32'hA500_0080, st);
        xfer("t3_exr_m1", 32'h200, 0, 1, 8'd1, 0, 1, 0, 1, 32'hA500_0080, st);
        xfer("t3_exw_m1", 32'h200, 1, 1, 8'd1, 32'h5555, 1, 0, 0, 0, st);
        xfer("t3_exw_m0", 32'h200, 1, 1, 8'd0, 32'h6666, 0, 1, 0, 0, st);
        xfer("t3_rd", 32'h200, 0, 0, 8'd0, 0, 0, 0, 1, 32'h5555, st);

        // No reservation, and out-of-range master.
        xfer("t4_exw_m1", 32'h300, 1, 1, 8'd1, 32'h7171, 0, 1, 0, 0, st);
        xfer("t4_exr_m5", 32'h300, 0, 1, 8'd5, 0, 0, 0, 1, 32'hA500_00C0, st);
        xfer("t4_exw_m5", 32'h300, 1, 1, 8'd5, 32'h7272, 0, 1, 0, 0, st);
        xfer("t4_rd", 32'h300, 0, 0, 8'd0, 0, 0, 0, 1, 32'hA500_00C0, st);

        // Slave stalls the exclusive read; reservation loaded once.
        ws_cfg = 3;
        xfer("t5_exr", 32'h400, 0, 1, 8'd0, 0, 1, 0, 1, 32'hA500_0100, st);
        chk("t5_stall_cycles", 32'(st), 32'd3);
        ws_cfg = 0;
        xfer("t5_exw", 32'h400, 1, 1, 8'd0, 32'h8888, 1, 0, 0, 0, st);
        xfer("t5_exw_again", 32'h400, 1, 1, 8'd0, 32'h9999, 0, 1, 0, 0, st);

        // Stale reservation: outcome depends on the timeout build option.
        xfer("t6_exr", 32'h500, 0, 1, 8'd0, 0, 1, 0, 1, 32'hA500_0140, st);
        repeat (9) @(posedge clk);
        #1;
        xfer("t6_exw", 32'h500, 1, 1, 8'd0, 32'h7777, !TO_EN, TO_EN, 0, 0, st);
        xfer("t6_rd", 32'h500, 0, 0, 8'd0, 0, 0, 0, 1,
             TO_EN ? 32'hA500_0140 : 32'h7777, st);

        // Asynchronous reset in the middle of a stalled exclusive read.
        ws_cfg      = 3;
        src_haddr   = 32'h600;
        src_hwrite  = 1'b0;
        src_hexcl   = 1'b1;
        src_hmaster = 8'd0;
        src_htrans  = HTRANS_NSEQ;
        @(negedge clk);
        chk("t7_accept_ready", 32'(src_hready), 32'd1);
        @(posedge clk);
        #1;
        idle_bus();
        @(negedge clk);
        chk("t7_hexokay_held", 32'(src_hexokay), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_hexokay", 32'(src_hexokay), 32'd0);
        chk("t7_rst_hready_resp", 32'(src_hready_resp), 32'd1);
        sb.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        ws_cfg = 0;
        @(posedge clk);
        #1;
        xfer("t7_exw", 32'h600, 1, 1, 8'd0, 32'hABCD, 0, 1, 0, 0, st);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ahbl_excl_monitor.md
Name: ahbl_excl_monitor

Overview:
- Global exclusive-access monitor placed inline between the N:1 AHBL arbiter's master port and the downstream shared slave (SRAM or bridge).
- Consumes the arbiter's hexcl/hmaster qualifiers and keeps one address reservation per master.
- Produces the hexokay data-phase response.
- Suppresses failed exclusive writes before they reach the slave; all other traffic passes straight through.

Parameters:
- W_ADDR, 32: address width.
- W_DATA, 32: data width.
- N_MASTERS, 2: number of reservation slots; indexed by hmaster.
- GRANULE_LOG2, 2: reservation granule is 2^GRANULE_LOG2 bytes; compare haddr[W_ADDR-1:GRANULE_LOG2].
- TIMEOUT_CYCLES, 1024: reservation lifetime, used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- src_hready  in  1  upstream bus ready; address phase accepted when high.
- src_hready_resp  out  1  upstream data-phase ready.
- src_hresp  out  1  upstream error response.
- src_haddr, src_hwrite, src_htrans[1:0], src_hsize[2:0], src_hburst[2:0], src_hprot[3:0], src_hmastlock  in  AHBL address-phase signals from the arbiter.
- src_hwdata  in  W_DATA  write data.
- src_hrdata  out  W_DATA  read data.
- src_hexcl  in  1  exclusive qualifier.
- src_hmaster  in  8  master ID.
- src_hexokay  out  1  exclusive success, valid when src_hready_resp=1.
- dst_hready  out  1  equals src_hready.
- dst_hready_resp, dst_hresp, dst_hrdata  in  downstream slave response.
- dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata  out  passthrough to the slave; dst_htrans is forced to IDLE on suppression.

Behaviour:
- Accept is src_hready & src_htrans[1]. All reservation updates commit at accept.
- Per-slot state is {valid, tag}, where tag = haddr[W_ADDR-1:GRANULE_LOG2]. Reset clears every valid bit.
- Exclusive read (hexcl=1, hwrite=0), hmaster < N_MASTERS:
  - Load slot[hmaster] with valid=1 and the new tag; any older tag in that slot is overwritten.
  - Forward the transfer unchanged.
  - Data phase: hexokay=1.
- Exclusive write, slot[hmaster] valid with matching tag (success):
  - Forward the write.
  - Clear every slot whose tag matches, including the writer's own.
  - Data phase: hexokay=1.
- Exclusive write that fails (no reservation, tag mismatch, or hmaster >= N_MASTERS):
  - Drive dst_htrans=2'b00; other dst signals pass through unchanged.
  - Clear slot[hmaster] if it is in range.
  - Register suppress_d=1.
  - Data phase: src_hready_resp=1 on the first cycle, src_hresp=0, hexokay=0, no slave write.
- Exclusive read with hmaster >= N_MASTERS: forwarded, no slot loaded, hexokay=0.
- Non-exclusive write from any master: forwarded, and every slot with a matching tag is cleared.
- Non-exclusive read: no state change.
- Data-phase registers excl_d, okay_d and suppress_d load on src_hready.
  - src_hexokay = excl_d & okay_d.
  - src_hready_resp = suppress_d | dst_hready_resp.
  - src_hresp = ~suppress_d & dst_hresp.
  - src_hrdata = dst_hrdata.
- Reset values: all slots invalid, excl_d=okay_d=suppress_d=0, therefore src_hexokay=0 and the response path is passthrough.
- Latency: zero added cycles on passthrough; a suppressed write completes in one data-phase cycle.
- Simultaneous events:
  - Accept while the previous data phase is stalled (src_hready=0): no accept, no state change.
  - Exclusive write success and a slot's timeout expiring in the same cycle: the clear wins.
- An error response from the slave does not restore a cleared reservation.
- Asynchronous reset mid-transfer: all state cleared immediately; any in-flight exclusive is lost and treated as failed by software retry.

Optional Feature:
- Macro: AHBL_EXCL_MONITOR_TIMEOUT_EN.
- When defined:
  - Each slot has a counter, sized as $clog2(TIMEOUT_CYCLES+1), loaded to TIMEOUT_CYCLES when the slot is set.
  - The counter decrements each cycle while the slot is valid; at 0 the slot's valid bit clears.
  - This bounds how long a stale reservation can persist.
- When undefined: no counters, and a reservation lives until it is cleared by the rules above.

Decomposition:
- Shared package ahbl_pkg:
  - HTRANS_IDLE/BUSY/NSEQ/SEQ constants.
  - Reservation tag width function (W_ADDR-GRANULE_LOG2).
- Sub-module ahbl_excl_rsv_slot: one reservation (valid, tag, optional timeout counter), with set/clear/match ports. Instantiated N_MASTERS times.

Test Plan:
- M0 exclusive read 0x100, then M0 exclusive write 0x100 → dst write seen, hexokay=1, slot0 invalid afterwards.
- M0 exclusive read 0x100, M1 plain write 0x104 (same granule when GRANULE_LOG2=3), M0 exclusive write 0x100 → dst_htrans=IDLE on the write, src_hready_resp=1 next cycle, hexokay=0, memory unchanged.
- M0 and M1 both exclusive read 0x200, M1 exclusive write succeeds → M0's following exclusive write 0x200 fails with hexokay=0.
- Exclusive write with no prior reservation, and exclusive write with hmaster=5 (N_MASTERS=2) → both suppressed, hresp=0, hexokay=0.
- Slave holds dst_hready_resp=0 for 3 cycles during an exclusive read → hexokay held until the ready cycle, no second slot load.
- With AHBL_EXCL_MONITOR_TIMEOUT_EN and TIMEOUT_CYCLES=8: exclusive read, idle 9 cycles, exclusive write → fails. Without the macro the same sequence succeeds.
- Assert rst_n mid exclusive read data phase → src_hexokay=0 immediately, all slots invalid.
